ct_ciu_ctcq_respq_ctrl: RTL and testbench

CT_CIU_CTCQ_RESPQ_CTRL -- requirements
Module: ct_ciu_ctcq_respq_ctrl

---
 rtl/ct_ciu_ctcq_respq_ctrl.sv | 78 +++++++
 tb/tb_ct_ciu_ctcq_respq_ctrl.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/ct_ciu_ctcq_respq_ctrl.sv
// ct_ciu_ctcq_respq_ctrl: 4-entry in-order queue tracking per-source responses for CTCQ transactions
module ct_ciu_ctcq_respq_ctrl (
  input  logic        forever_cpuclk,
  input  logic        cpurst,
  input  logic        ctcq_create_vld,
  output logic        ctcq_create_rdy,
  input  logic [5:0]  ctcq_create_need,
  input  logic        ctcq_create_dvm,
  output logic [1:0]  ctcq_create_id,
  input  logic [5:0]  resp_vld,
  input  logic [11:0] resp_id,
  output logic        respq_done_vld,
  input  logic        respq_done_rdy,
  output logic [1:0]  respq_done_id,
  output logic        respq_done_dvm,
  output logic [2:0]  respq_cnt,
  output logic        respq_err
);
  logic [3:0]      vld;
  logic [3:0][5:0] cmplt;
  logic [3:0]      dvm;
  logic [1:0]      head;
  logic [1:0]      tail;
  logic [2:0]      cnt;
  logic            err;
  logic [3:0][5:0] set_bits;
  logic            err_hit;
  logic [1:0]      rid;
  logic            create_fire;
  logic            pop_fire;
  assign ctcq_create_rdy = cnt != 3'd4;
  assign ctcq_create_id  = tail;
  assign create_fire     = ctcq_create_vld & ctcq_create_rdy;
  assign respq_done_vld  = vld[head] & (&cmplt[head]);
  assign respq_done_id   = head;
  assign respq_done_dvm  = dvm[head];
  assign pop_fire        = respq_done_vld & respq_done_rdy;
  assign respq_cnt       = cnt;
  assign respq_err       = err;
  // Responses only land on entries valid in registered state, so one aimed at the slot being created this cycle is an error
  always_comb begin
    set_bits = '0;
    err_hit  = 1'b0;
    rid      = '0;
    for (int k = 0; k < 6; k++) begin
      rid = resp_id[2*k +: 2];
      if (resp_vld[k] && vld[rid] && !cmplt[rid][k]) set_bits[rid][k] = 1'b1;
      else if (resp_vld[k]) err_hit = 1'b1;
    end
  end
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      head  <= '0;
      tail  <= '0;
      cnt   <= '0;
      vld   <= '0;
      cmplt <= '0;
      err   <= 1'b0;
    end else begin
      cmplt <= cmplt | set_bits;
      err   <= err | err_hit;
      if (create_fire) begin
        vld[tail]   <= 1'b1;
        cmplt[tail] <= ~ctcq_create_need;
        tail        <= tail + 2'd1;
      end
      if (pop_fire) begin
        vld[head] <= 1'b0;
        head      <= head + 2'd1;
      end
      cnt <= cnt + {2'b0, create_fire} - {2'b0, pop_fire};
    end
  end
  // The dvm flag is only observed while its entry is valid, so it needs no reset
  always_ff @(posedge forever_cpuclk) begin
    if (create_fire) dvm[tail] <= ctcq_create_dvm;
  end
endmodule

// File: tb/tb_ct_ciu_ctcq_respq_ctrl.sv
// tb_ct_ciu_ctcq_respq_ctrl: directed vector bench for the CTCQ response queue
module tb_ct_ciu_ctcq_respq_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        cv;
  logic        rdy;
  logic [5:0]  need;
  logic        dvm;
  logic [1:0]  cid;
  logic [5:0]  rv;
  logic [11:0] rid;
  logic        dv;
  logic        dr;
  logic [1:0]  did;
  logic        dd;
  logic [2:0]  cnt;
  logic        err;
  int          n_cmp = 0;
  int          n_bad = 0;

  typedef struct {
    logic        rst;
    logic        cv;
    logic [5:0]  need;
    logic        dvm;
    logic [5:0]  rv;
    logic [11:0] rid;
    logic        dr;
    logic        rdy;
    logic [1:0]  id;
    logic        dv;
    logic [1:0]  did;
    logic        dd;
    logic [2:0]  cnt;
    logic        err;
  } vec_t;

  vec_t tbl[$];
  vec_t hand[$];

  ct_ciu_ctcq_respq_ctrl dut (
    .forever_cpuclk   (clk),
    .cpurst           (rst),
    .ctcq_create_vld  (cv),
    .ctcq_create_rdy  (rdy),
    .ctcq_create_need (need),
    .ctcq_create_dvm  (dvm),
    .ctcq_create_id   (cid),
    .resp_vld         (rv),
    .resp_id          (rid),
    .respq_done_vld   (dv),
    .respq_done_rdy   (dr),
    .respq_done_id    (did),
    .respq_done_dvm   (dd),
    .respq_cnt        (cnt),
    .respq_err        (err)
  );

  always #5 clk = ~clk;

  function automatic vec_t v(logic r, logic c, logic [5:0] nd, logic dm, logic [5:0] rvl, logic [11:0] ri,
                             logic drd, logic e_rdy, logic [1:0] e_id, logic e_dv, logic [1:0] e_did,
                             logic e_dd, logic [2:0] e_cnt, logic e_err);
    vec_t t;
    t.rst = r; t.cv = c; t.need = nd; t.dvm = dm; t.rv = rvl; t.rid = ri; t.dr = drd;
    t.rdy = e_rdy; t.id = e_id; t.dv = e_dv; t.did = e_did; t.dd = e_dd; t.cnt = e_cnt; t.err = e_err;
    return t;
  endfunction

  // Drive on the falling edge, compare the pre-edge outputs 1 ns later, then let the rising edge commit
  task automatic run(input vec_t t, input string nm);
    logic [9:0] got, exp;
    @(negedge clk);
    rst = t.rst; cv = t.cv; need = t.need; dvm = t.dvm; rv = t.rv; rid = t.rid; dr = t.dr;
    #1;
    got = {rdy, cid, dv, did, cnt, err};
    exp = {t.rdy, t.id, t.dv, t.did, t.cnt, t.err};
    n_cmp++;
    if (got !== exp || (t.dv && dd !== t.dd)) begin
      n_bad++;
      $display("FAIL %s: got rdy=%b id=%0d dv=%b did=%0d dd=%b cnt=%0d err=%b, want rdy=%b id=%0d dv=%b did=%0d dd=%b cnt=%0d err=%b",
               nm, rdy, cid, dv, did, dd, cnt, err, t.rdy, t.id, t.dv, t.did, t.dd, t.cnt, t.err);
    end
  endtask

  initial begin
    rst = 1'b1; cv = 1'b0; need = '0; dvm = 1'b0; rv = '0; rid = '0; dr = 1'b0;
    repeat (2) @(posedge clk);
    //       rst  cv    need       dvm   rv         rid       dr    rdy   id    dv    did   dd    cnt   err
    tbl.push_back(v(0, 0, 6'b000000, 0, 6'b000000, 12'h000, 0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 1, 6'b100001, 1, 6'b000000, 12'h000, 0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 6'b000000, 0, 6'b000001, 12'h000, 0, 1, 1, 0, 0, 0, 1, 0));
    tbl.push_back(v(0, 0, 6'b000000, 0, 6'b100000, 12'h000, 0, 1, 1, 0, 0, 0, 1, 0));
    tbl.push_back(v(0, 0, 6'b000000, 0, 6'b000000, 12'h000, 1, 1, 1, 1, 0, 1, 1, 0));
    tbl.push_back(v(0, 0, 6'b000000, 0, 6'b000000, 12'h000, 0, 1, 1, 0, 1, 0, 0, 0));
    tbl.push_back(v(0, 1, 6'b000000, 0, 6'b000000, 12'h000, 0, 1, 1, 0, 1, 0, 0, 0));
    tbl.push_back(v(0, 0, 6'b000000, 0, 6'b000000, 12'h000, 0, 1, 2, 1, 1, 0, 1, 0));
    tbl.push_back(v(0, 0, 6'b000000, 0, 6'b000000, 12'h000, 1, 1, 2, 1, 1, 0, 1, 0));
    tbl.push_back(v(0, 0, 6'b000000, 0, 6'b000000, 12'h000, 0, 1, 2, 0, 2, 0, 0, 0));
    tbl.push_back(v(1, 1, 6'b000000, 0, 6'b000001, 12'h000, 0, 1, 2, 0, 2, 0, 0, 0));
    tbl.push_back(v(0, 0, 6'b000000, 0, 6'b000000, 12'h000, 0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 1, 6'b000010, 0, 6'b000000, 12'h000, 0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 1, 6'b000010, 1, 6'b000000, 12'h000, 0, 1, 1, 0, 0, 0, 1, 0));
    tbl.push_back(v(0, 1, 6'b000010, 0, 6'b000000, 12'h000, 0, 1, 2, 0, 0, 0, 2, 0));
    tbl.push_back(v(0, 1, 6'b000010, 1, 6'b000000, 12'h000, 0, 1, 3, 0, 0, 0, 3, 0));
    tbl.push_back(v(0, 1, 6'b000010, 0, 6'b000000, 12'h000, 0, 0, 0, 0, 0, 0, 4, 0));
    tbl.push_back(v(0, 0, 6'b000000, 0, 6'b000010, 12'h008, 0, 0, 0, 0, 0, 0, 4, 0));
    tbl.push_back(v(0, 0, 6'b000000, 0, 6'b000000, 12'h000, 0, 0, 0, 0, 0, 0, 4, 0));
    tbl.push_back(v(0, 0, 6'b000000, 0, 6'b000010, 12'h000, 0, 0, 0, 0, 0, 0, 4, 0));
    tbl.push_back(v(0, 0, 6'b000000, 0, 6'b000000, 12'h000, 0, 0, 0, 1, 0, 0, 4, 0));
    tbl.push_back(v(0, 1, 6'b000000, 1, 6'b000000, 12'h000, 1, 0, 0, 1, 0, 0, 4, 0));
    tbl.push_back(v(0, 0, 6'b000000, 0, 6'b000000, 12'h000, 0, 1, 0, 0, 1, 0, 3, 0));
    tbl.push_back(v(0, 0, 6'b000000, 0, 6'b000001, 12'h000, 0, 1, 0, 0, 1, 0, 3, 0));
    tbl.push_back(v(0, 0, 6'b000000, 0, 6'b000000, 12'h000, 0, 1, 0, 0, 1, 0, 3, 1));
    tbl.push_back(v(0, 0, 6'b000000, 0, 6'b000010, 12'h008, 0, 1, 0, 0, 1, 0, 3, 1));
    tbl.push_back(v(0, 0, 6'b000000, 0, 6'b000000, 12'h000, 0, 1, 0, 0, 1, 0, 3, 1));
    tbl.push_back(v(0, 0, 6'b000000, 0, 6'b000010, 12'h004, 0, 1, 0, 0, 1, 0, 3, 1));
    tbl.push_back(v(0, 0, 6'b000000, 0, 6'b000000, 12'h000, 0, 1, 0, 1, 1, 1, 3, 1));
    tbl.push_back(v(0, 0, 6'b000000, 0, 6'b000000, 12'h000, 1, 1, 0, 1, 1, 1, 3, 1));
    tbl.push_back(v(0, 0, 6'b000000, 0, 6'b000000, 12'h000, 0, 1, 0, 1, 2, 0, 2, 1));
    tbl.push_back(v(0, 0, 6'b000000, 0, 6'b000000, 12'h000, 1, 1, 0, 1, 2, 0, 2, 1));
    tbl.push_back(v(0, 0, 6'b000000, 0, 6'b000000, 12'h000, 0, 1, 0, 0, 3, 0, 1, 1));
    tbl.push_back(v(0, 0, 6'b000000, 0, 6'b000010, 12'h00C, 0, 1, 0, 0, 3, 0, 1, 1));
    tbl.push_back(v(0, 1, 6'b000001, 0, 6'b000000, 12'h000, 1, 1, 0, 1, 3, 1, 1, 1));
    tbl.push_back(v(0, 0, 6'b000000, 0, 6'b000000, 12'h000, 0, 1, 1, 0, 0, 0, 1, 1));
    foreach (tbl[i]) run(tbl[i], $sformatf("vec%0d", i));

    // Multi-source completion, same-cycle create/response race, and mid-traffic reset
    hand.push_back(v(1, 0, 6'b000000, 0, 6'b000000, 12'h000, 0, 1, 1, 0, 0, 0, 1, 1));
    hand.push_back(v(0, 1, 6'b110011, 1, 6'b000000, 12'h000, 0, 1, 0, 0, 0, 0, 0, 0));
    hand.push_back(v(0, 0, 6'b000000, 0, 6'b110011, 12'h000, 0, 1, 1, 0, 0, 0, 1, 0));
    hand.push_back(v(0, 0, 6'b000000, 0, 6'b000000, 12'h000, 0, 1, 1, 1, 0, 1, 1, 0));
    hand.push_back(v(0, 0, 6'b000000, 0, 6'b000000, 12'h000, 1, 1, 1, 1, 0, 1, 1, 0));
    hand.push_back(v(0, 1, 6'b000001, 0, 6'b000001, 12'h001, 0, 1, 1, 0, 1, 0, 0, 0));
    hand.push_back(v(0, 0, 6'b000000, 0, 6'b000000, 12'h000, 0, 1, 2, 0, 1, 0, 1, 1));
    hand.push_back(v(0, 0, 6'b000000, 0, 6'b000001, 12'h001, 0, 1, 2, 0, 1, 0, 1, 1));
    hand.push_back(v(0, 0, 6'b000000, 0, 6'b000000, 12'h000, 0, 1, 2, 1, 1, 0, 1, 1));
    hand.push_back(v(0, 1, 6'b000001, 0, 6'b000000, 12'h000, 0, 1, 2, 1, 1, 0, 1, 1));
    hand.push_back(v(0, 1, 6'b000001, 0, 6'b000000, 12'h000, 0, 1, 3, 1, 1, 0, 2, 1));
    hand.push_back(v(1, 1, 6'b000001, 0, 6'b000001, 12'h002, 1, 1, 0, 1, 1, 0, 3, 1));
    hand.push_back(v(0, 0, 6'b000000, 0, 6'b000000, 12'h000, 0, 1, 0, 0, 0, 0, 0, 0));
    hand.push_back(v(0, 1, 6'b000000, 1, 6'b000000, 12'h000, 0, 1, 0, 0, 0, 0, 0, 0));
    hand.push_back(v(0, 0, 6'b000000, 0, 6'b000000, 12'h000, 0, 1, 1, 1, 0, 1, 1, 0));
    foreach (hand[i]) run(hand[i], $sformatf("seq%0d", i));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
